startup_pattern_driver: RTL and testbench
=========================================

// Module: startup_pattern_driver
// PURPOSE
//  Datapath partner of the startup display FSM; consumes its CLEAR/DISP/LOAD_PAT/NXT_ADR/RST_TIMER strobes.
//  Returns TIMER and DONE to the FSM.
//  Holds the pattern ROM address counter, pattern register and interval timer.
//  Drives the front-panel LEDs in parallel, and serially to the external LED driver (SCLK/SDAT/SLATCH).
// PARAMETERS
//  NLED      8   LED count / pattern width
//  NPAT      16  ROM entries; entry 0 is reserved blank (all off)
//  AW        4   address width, clog2(NPAT)
//  SCLK_DIV  4   CLK cycles per SCLK half-period (>=2)
// PORTS
//  CLK        in   1     system clock
//  RST        in   1     asynchronous, active-high reset
//  CLEAR      in   1     zero address and pattern register
//  DISP       in   1     1 = show pattern, 0 = blank LEDs
//  LOAD_PAT   in   1     latch ROM output into pattern register
//  NXT_ADR    in   1     advance ROM address
//  RST_TIMER  in   1     hold TIMER at 0
//  TIMER      out  16    interval count
//  DONE       out  1     current address is last entry (NPAT-1)
//  LED        out  NLED  parallel LED drive
//  SCLK       out  1     serial clock to LED driver
//  SDAT       out  1     serial data, MSB first
//  SLATCH     out  1     latch strobe to LED driver
//  BUSY       out  1     serial frame in progress
// BEHAVIOUR
//  Reset: all outputs 0; ADR=0; PAT=0; ROM_Q=0; shifter IDLE, no pending frame. Reset is asynchronous and mid-frame reset aborts the frame.
//  Timer: RST_TIMER=1 -> TIMER<=0. Else TIMER<=TIMER+1, saturating at 16'hFFFF (no wrap).
//   TIMER reads N after N cycles with RST_TIMER=0; FSM compares against 16'hBB8.
//  Address: priority CLEAR > NXT_ADR.
//   CLEAR -> ADR<=0.
//   NXT_ADR -> ADR<=ADR+1 when ADR<NPAT-1, else ADR holds (no wrap).
//  ROM: synchronous read, ROM_Q<=ROM[ADR] every cycle (1-cycle latency).
//   The NXT_ADR -> idle -> LOAD_PAT strobe spacing therefore loads ROM[new ADR].
//  DONE: registered, DONE<=(ADR==NPAT-1). Valid by the LOAD_PAT cycle.
//  Pattern: CLEAR -> PAT<=0; else LOAD_PAT -> PAT<=ROM_Q; CLEAR wins if both are asserted.
//  LED: registered, LED<=DISP?PAT:0. One cycle after PAT/DISP change.
//  Serial shifter, states IDLE/LOW/HIGH/LATCH:
//   IDLE: if LED!=SENT or PEND, capture SHREG<=LED, SENT<=LED, clear PEND, BUSY=1 -> LOW.
//   LOW: SCLK=0, SDAT=SHREG[MSB], for SCLK_DIV cycles -> HIGH.
//   HIGH: SCLK=1, for SCLK_DIV cycles; driver samples on rising edge.
//    Then shift left. After NLED bits -> LATCH, else -> LOW.
//   LATCH: SLATCH=1, SCLK=0, for SCLK_DIV cycles -> IDLE, BUSY=0.
//  Frame length: (2*NLED+1)*SCLK_DIV cycles; 68 at defaults, well inside the 3000-cycle display interval.
//  LED changes while BUSY: set PEND. Exactly one extra frame of the latest LED value follows; intermediate values are dropped.
//  SENT resets to 0, so there is no frame after reset until LED becomes nonzero.
// STRUCTURE
//  Package startup_disp_pkg: NLED/NPAT defaults, ROM contents constant array, shifter state encoding.
//  Sub-module led_serial_shifter (IDLE/LOW/HIGH/LATCH FSM, divider, bit counter, PEND).
//  Top level: timer, address counter, ROM, PAT/LED/DONE registers.
// TESTING
//  1 RST pulse mid-frame (bit 3) -> next cycle all outputs 0, TIMER=0, BUSY=0, no SLATCH after release.
//  2 RST_TIMER=0 for 3000 cycles -> TIMER=16'hBB8. RST_TIMER=1 -> 0 next cycle. 70000 free cycles -> holds 16'hFFFF.
//  3 DISP=1: NXT_ADR 1 cyc, idle 1 cyc, LOAD_PAT 1 cyc -> PAT=ROM[1], LED=ROM[1] next cycle, DONE=0.
//  4 NPAT-1 NXT/LOAD sequences -> DONE=1 in final LOAD_PAT cycle. Further NXT_ADR -> ADR stays 15.
//  5 CLEAR and NXT_ADR together -> ADR=0, PAT=0.
//    DISP=0 with PAT=8'h3C -> LED=0, and the 8'h00 frame is shifted.
//  6 LED 0->8'hA5 -> SDAT 1,0,1,0,0,1,0,1 at SCLK rises, one SLATCH, BUSY 68 cycles.
//    Change to 8'h5A mid-frame -> a second 8'h5A frame immediately follows.

Source files
------------

// File: rtl/startup_disp_pkg.sv
// Shared definitions for the startup pattern driver: default sizes, the
// pattern ROM image and the serial shifter state encoding.
package startup_disp_pkg;

    localparam int NLED_DEF     = 8;
    localparam int NPAT_DEF     = 16;
    localparam int AW_DEF       = 4;
    localparam int SCLK_DIV_DEF = 4;
    localparam int TW           = 16;

    typedef logic [NLED_DEF-1:0] pat_t;

    // Entry 0 stays blank so that address 0 always shows all LEDs off.
    localparam pat_t PAT_ROM [NPAT_DEF] = '{
        8'h00, 8'h3C, 8'hA5, 8'h5A, 8'h81, 8'hC3, 8'hE7, 8'hFF,
        8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hAA
    };

    typedef enum logic [1:0] {
        SH_IDLE  = 2'd0,
        SH_LOW   = 2'd1,
        SH_HIGH  = 2'd2,
        SH_LATCH = 2'd3
    } sh_state_e;

endpackage

// File: rtl/led_serial_shifter.sv
// Serialises the LED vector MSB first to an external LED driver, followed by a
// latch strobe; remembers one pending refresh if LED changes mid-frame.
module led_serial_shifter
    import startup_disp_pkg::*;
#(
    parameter int NLED     = NLED_DEF,
    parameter int SCLK_DIV = SCLK_DIV_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NLED-1:0] led_i,
    output logic            sclk_o,
    output logic            sdat_o,
    output logic            slatch_o,
    output logic            busy_o
);

    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BW = (NLED > 1) ? $clog2(NLED) : 1;

    sh_state_e       state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [NLED-1:0] shreg_q, shreg_d;
    logic [NLED-1:0] sent_q, sent_d;
    logic            pend_q, pend_d;
    logic            div_last;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SH_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sent_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sent_q  <= sent_d;
            pend_q  <= pend_d;
        end
    end

    assign div_last = (div_q == DW'(SCLK_DIV - 1));

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sent_d  = sent_q;
        pend_d  = pend_q;

        unique case (state_q)
            SH_IDLE: begin
                if ((led_i != sent_q) || pend_q) begin
                    shreg_d = led_i;
                    sent_d  = led_i;
                    pend_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = SH_LOW;
                end
            end
            SH_LOW: begin
                div_d = div_q + 1'b1;
                if (div_last) begin
                    div_d   = '0;
                    state_d = SH_HIGH;
                end
            end
            SH_HIGH: begin
                div_d = div_q + 1'b1;
                if (div_last) begin
                    div_d   = '0;
                    shreg_d = shreg_q << 1;
                    if (bit_q == BW'(NLED - 1)) begin
                        bit_d   = '0;
                        state_d = SH_LATCH;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = SH_LOW;
                    end
                end
            end
            SH_LATCH: begin
                div_d = div_q + 1'b1;
                if (div_last) begin
                    div_d   = '0;
                    state_d = SH_IDLE;
                end
            end
            default: state_d = SH_IDLE;
        endcase

        // A value differing from the frame in flight earns exactly one refresh.
        if ((state_q != SH_IDLE) && (led_i != sent_q)) begin
            pend_d = 1'b1;
        end
    end

    always_comb begin
        sclk_o   = 1'b0;
        sdat_o   = 1'b0;
        slatch_o = 1'b0;
        busy_o   = (state_q != SH_IDLE);
        unique case (state_q)
            SH_LOW:   sdat_o = shreg_q[NLED-1];
            SH_HIGH: begin
                sclk_o = 1'b1;
                sdat_o = shreg_q[NLED-1];
            end
            SH_LATCH: slatch_o = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: rtl/startup_pattern_driver.sv
// Datapath partner of the startup display FSM: interval timer, pattern ROM
// address counter, pattern/LED registers and the serial LED driver link.
module startup_pattern_driver
    import startup_disp_pkg::*;
#(
    parameter int NLED     = NLED_DEF,
    parameter int NPAT     = NPAT_DEF,
    parameter int AW       = AW_DEF,
    parameter int SCLK_DIV = SCLK_DIV_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CLEAR,
    input  logic            DISP,
    input  logic            LOAD_PAT,
    input  logic            NXT_ADR,
    input  logic            RST_TIMER,
    output logic [TW-1:0]   TIMER,
    output logic            DONE,
    output logic [NLED-1:0] LED,
    output logic            SCLK,
    output logic            SDAT,
    output logic            SLATCH,
    output logic            BUSY
);

    logic [TW-1:0]   timer_q, timer_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [NLED-1:0] rom_q, rom_d;
    logic [NLED-1:0] pat_q, pat_d;
    logic [NLED-1:0] led_q, led_d;
    logic            done_q, done_d;

    always_comb begin
        timer_d = timer_q;
        if (RST_TIMER) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end

        adr_d = adr_q;
        if (CLEAR) begin
            adr_d = '0;
        end else if (NXT_ADR && (adr_q != AW'(NPAT - 1))) begin
            adr_d = adr_q + 1'b1;
        end

        pat_d = pat_q;
        if (CLEAR) begin
            pat_d = '0;
        end else if (LOAD_PAT) begin
            pat_d = rom_q;
        end

        rom_d  = NLED'(PAT_ROM[adr_q]);
        led_d  = DISP ? pat_q : '0;
        done_d = (adr_q == AW'(NPAT - 1));
    end

    // The ROM output register is reset as well, so a LOAD_PAT straight out of
    // reset latches the blank entry instead of an unknown value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timer_q <= '0;
            adr_q   <= '0;
            rom_q   <= '0;
            pat_q   <= '0;
            led_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            timer_q <= timer_d;
            adr_q   <= adr_d;
            rom_q   <= rom_d;
            pat_q   <= pat_d;
            led_q   <= led_d;
            done_q  <= done_d;
        end
    end

    assign TIMER = timer_q;
    assign DONE  = done_q;
    assign LED   = led_q;

    led_serial_shifter #(
        .NLED     (NLED),
        .SCLK_DIV (SCLK_DIV)
    ) u_shifter (
        .clk_i    (CLK),
        .rst_i    (RST),
        .led_i    (led_q),
        .sclk_o   (SCLK),
        .sdat_o   (SDAT),
        .slatch_o (SLATCH),
        .busy_o   (BUSY)
    );

endmodule

// File: tb/tb_startup_pattern_driver.sv
// Directed bench for startup_pattern_driver: cycle vector table for the
// address/pattern path plus hand sequences for frames, reset and timer.
module tb_startup_pattern_driver;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CLEAR, DISP, LOAD_PAT, NXT_ADR, RST_TIMER;
    logic [15:0] TIMER;
    logic        DONE;
    logic [7:0]  LED;
    logic        SCLK, SDAT, SLATCH, BUSY;

    int n_cmp  = 0;
    int n_fail = 0;

    startup_pattern_driver dut (
        .CLK       (CLK),
        .RST       (RST),
        .CLEAR     (CLEAR),
        .DISP      (DISP),
        .LOAD_PAT  (LOAD_PAT),
        .NXT_ADR   (NXT_ADR),
        .RST_TIMER (RST_TIMER),
        .TIMER     (TIMER),
        .DONE      (DONE),
        .LED       (LED),
        .SCLK      (SCLK),
        .SDAT      (SDAT),
        .SLATCH    (SLATCH),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    // Expected ROM image, written out independently of the design package.
    logic [7:0] rom_exp [16] = '{
        8'h00, 8'h3C, 8'hA5, 8'h5A, 8'h81, 8'hC3, 8'hE7, 8'hFF,
        8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hAA
    };

    typedef struct {
        logic       clear;
        logic       disp;
        logic       load;
        logic       nxt;
        logic [7:0] exp_led;
        logic       exp_done;
    } vec_t;

    vec_t vecs [15];

    // Serial link observer, sampled on the falling edge.
    logic [7:0] mon_acc = '0;
    logic [7:0] last_frame = '0;
    int mon_nbits = 0, mon_run = 0, mon_idle = 0;
    int frames = 0, latch_cnt = 0, last_bits = 0, last_len = 0, last_gap = 0;
    logic prev_sclk = 1'b0, prev_slatch = 1'b0, prev_busy = 1'b0;

    always @(negedge CLK) begin
        if (RST) begin
            mon_acc     <= '0;
            mon_nbits   <= 0;
            mon_run     <= 0;
            prev_sclk   <= 1'b0;
            prev_slatch <= 1'b0;
            prev_busy   <= 1'b0;
        end else begin
            if (SCLK && !prev_sclk) begin
                mon_acc   <= {mon_acc[6:0], SDAT};
                mon_nbits <= mon_nbits + 1;
            end
            if (SLATCH && !prev_slatch) latch_cnt <= latch_cnt + 1;
            if (BUSY) mon_run <= mon_run + 1;
            if (!BUSY) mon_idle <= mon_idle + 1;
            if (BUSY && !prev_busy) begin
                last_gap <= mon_idle;
                mon_idle <= 0;
            end
            if (!BUSY && prev_busy) begin
                frames     <= frames + 1;
                last_frame <= mon_acc;
                last_bits  <= mon_nbits;
                last_len   <= mon_run;
                mon_run    <= 0;
                mon_nbits  <= 0;
            end
            prev_sclk   <= SCLK;
            prev_slatch <= SLATCH;
            prev_busy   <= BUSY;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic c, input logic d, input logic l, input logic n);
        CLEAR    = c;
        DISP     = d;
        LOAD_PAT = l;
        NXT_ADR  = n;
    endtask

    task automatic wait_frames(input int target, input string name);
        for (int i = 0; i < 300 && frames < target; i++) tick();
        check(name, 32'(frames), 32'(target));
    endtask

    task automatic wait_quiet();
        int quiet;
        quiet = 0;
        for (int i = 0; i < 400 && quiet < 3; i++) begin
            tick();
            quiet = BUSY ? 0 : quiet + 1;
        end
        check("link_quiet", 32'(BUSY), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_led"},    32'(LED),    32'd0);
        check({tag, "_done"},   32'(DONE),   32'd0);
        check({tag, "_timer"},  32'(TIMER),  32'd0);
        check({tag, "_sclk"},   32'(SCLK),   32'd0);
        check({tag, "_sdat"},   32'(SDAT),   32'd0);
        check({tag, "_slatch"}, 32'(SLATCH), 32'd0);
        check({tag, "_busy"},   32'(BUSY),   32'd0);
    endtask

    initial begin
        int f0, l0;

        //            clear disp  load  nxt   led    done
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0};

        RST = 1'b1;
        RST_TIMER = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_all_zero("reset");
        RST = 1'b0;

        // Address/pattern/LED path, one vector per clock.
        for (int i = 0; i < 15; i++) begin
            set_in(vecs[i].clear, vecs[i].disp, vecs[i].load, vecs[i].nxt);
            tick();
            check($sformatf("vec%0d_led", i), 32'(LED), 32'(vecs[i].exp_led));
            check($sformatf("vec%0d_done", i), 32'(DONE), 32'(vecs[i].exp_done));
        end

        // Walk the remaining entries; DONE must rise only for the last one.
        for (int k = 2; k < 16; k++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b1); tick();
            set_in(1'b0, 1'b1, 1'b0, 1'b0); tick();
            check($sformatf("walk%0d_done", k), 32'(DONE), (k == 15) ? 32'd1 : 32'd0);
            set_in(1'b0, 1'b1, 1'b1, 1'b0); tick();
            set_in(1'b0, 1'b1, 1'b0, 1'b0); tick();
            check($sformatf("walk%0d_led", k), 32'(LED), 32'(rom_exp[k]));
        end
        set_in(1'b0, 1'b1, 1'b0, 1'b1); tick();
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0); tick();
        set_in(1'b0, 1'b1, 1'b1, 1'b0); tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0); tick();
        check("adr_hold_done", 32'(DONE), 32'd1);
        check("adr_hold_led", 32'(LED), 32'hAA);

        set_in(1'b1, 1'b1, 1'b0, 1'b1); tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0); tick();
        check("clear_nxt_led", 32'(LED), 32'd0);
        check("clear_nxt_done", 32'(DONE), 32'd0);
        wait_quiet();

        // Single frame of 8'hA5.
        f0 = frames;
        l0 = latch_cnt;
        set_in(1'b0, 1'b1, 1'b0, 1'b1); tick();
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0); tick();
        set_in(1'b0, 1'b1, 1'b1, 1'b0); tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0); tick();
        check("a5_led", 32'(LED), 32'hA5);
        wait_frames(f0 + 1, "a5_frame_seen");
        check("a5_bits", 32'(last_frame), 32'hA5);
        check("a5_nbits", 32'(last_bits), 32'd8);
        check("a5_busy_len", 32'(last_len), 32'd68);
        check("a5_latches", 32'(latch_cnt), 32'(l0 + 1));
        repeat (20) tick();
        check("a5_no_extra", 32'(frames), 32'(f0 + 1));

        // DISP=0 blanks the LEDs and the blank value is shifted out.
        f0 = frames;
        set_in(1'b0, 1'b0, 1'b0, 1'b0); tick();
        check("blank_led", 32'(LED), 32'd0);
        wait_frames(f0 + 1, "blank_frame_seen");
        check("blank_bits", 32'(last_frame), 32'd0);
        check("blank_busy_len", 32'(last_len), 32'd68);

        // LED changes to 8'h5A while an 8'hA5 frame is in flight.
        f0 = frames;
        l0 = latch_cnt;
        set_in(1'b0, 1'b1, 1'b0, 1'b0); tick();
        for (int i = 0; i < 20 && !BUSY; i++) tick();
        check("a5_again_busy", 32'(BUSY), 32'd1);
        repeat (8) tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b1); tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0); tick();
        set_in(1'b0, 1'b1, 1'b1, 1'b0); tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0); tick();
        check("mid_busy", 32'(BUSY), 32'd1);
        check("mid_led", 32'(LED), 32'h5A);
        wait_frames(f0 + 1, "pend_first_seen");
        check("pend_first_bits", 32'(last_frame), 32'hA5);
        wait_frames(f0 + 2, "pend_second_seen");
        check("pend_second_bits", 32'(last_frame), 32'h5A);
        check("pend_gap", 32'(last_gap), 32'd1);
        check("pend_latches", 32'(latch_cnt), 32'(l0 + 2));
        repeat (100) tick();
        check("pend_only_one", 32'(frames), 32'(f0 + 2));

        // Reset in the middle of a frame, after the third bit.
        set_in(1'b0, 1'b0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 100 && mon_nbits < 3; i++) tick();
        check("midframe_bit3", 32'(mon_nbits), 32'd3);
        f0 = frames;
        l0 = latch_cnt;
        RST = 1'b1;
        #1;
        check_all_zero("async_rst");
        tick();
        check_all_zero("rst_held");
        RST = 1'b0;
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (100) tick();
        check("post_rst_latches", 32'(latch_cnt), 32'(l0));
        check("post_rst_frames", 32'(frames), 32'(f0));
        check("post_rst_busy", 32'(BUSY), 32'd0);

        // Interval timer and saturation.
        RST_TIMER = 1'b1; tick();
        check("timer_clr", 32'(TIMER), 32'd0);
        RST_TIMER = 1'b0;
        repeat (3000) tick();
        check("timer_3000", 32'(TIMER), 32'h0BB8);
        RST_TIMER = 1'b1; tick();
        check("timer_clr2", 32'(TIMER), 32'd0);
        RST_TIMER = 1'b0;
        repeat (65534) tick();
        check("timer_fffe", 32'(TIMER), 32'hFFFE);
        tick();
        check("timer_ffff", 32'(TIMER), 32'hFFFF);
        repeat (70000 - 65535) tick();
        check("timer_sat", 32'(TIMER), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
